// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer between a pixel source and the 640x480@60 VGA output.
// Optional build macro VGA_LB_TESTPAT_EN adds I_pat_en to show eight colour bars instead of buffer data.
module vga_line_buffer #(
  parameter int H_ACTIVE = 640,
  parameter int H_START  = 144,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_START  = 35,
  parameter int DW       = 12
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic [11:0]   I_h_cnt,
  input  logic [11:0]   I_v_cnt,
  input  logic          I_hs,
  input  logic          I_vs,
  input  logic [DW-1:0] I_pix_data,
  input  logic          I_pix_valid,
`ifdef VGA_LB_TESTPAT_EN
  input  logic          I_pat_en,
`endif
  output logic          O_pix_ready,
  output logic          O_line_req,
  output logic [9:0]    O_line_num,
  output logic [3:0]    O_red,
  output logic [3:0]    O_green,
  output logic [3:0]    O_blue,
  output logic          O_hs,
  output logic          O_vs,
  output logic          O_underrun
);

  typedef enum logic {FILL, FULL} wr_state_t;

  wr_state_t     state;
  logic          wr_bank;
  logic          rd_bank;
  logic          rd_valid;
  logic          started;
  logic [9:0]    wr_ptr;
  logic [DW-1:0] bank0 [H_ACTIVE];
  logic [DW-1:0] bank1 [H_ACTIVE];

  logic          xfer;
  logic          last_xfer;
  logic          line_done;
  logic          swap;
  logic [11:0]   v_next;
  logic          h_act;
  logic          v_act;
  logic [9:0]    rd_addr;
  logic          pat_on;
  logic [DW-1:0] pat_pix;

  logic [DW-1:0] rgb_p1;
  logic          hs_p1;
  logic          vs_p1;

`ifdef VGA_LB_TESTPAT_EN
  function automatic logic [DW-1:0] bar_color(input logic [9:0] addr);
    logic [2:0] idx;
    idx = 3'(addr / 10'(H_ACTIVE / 8));
    case (idx)
      3'd0:    bar_color = 12'hF00;
      3'd1:    bar_color = 12'h0F0;
      3'd2:    bar_color = 12'h00F;
      3'd3:    bar_color = 12'hFFF;
      3'd4:    bar_color = 12'h000;
      3'd5:    bar_color = 12'hFF0;
      3'd6:    bar_color = 12'hF0F;
      default: bar_color = 12'h0FF;
    endcase
  endfunction

  assign pat_on  = I_pat_en;
  assign pat_pix = bar_color(rd_addr);
`else
  assign pat_on  = 1'b0;
  assign pat_pix = '0;
`endif

  assign xfer      = I_pix_valid && O_pix_ready;
  assign last_xfer = xfer && (wr_ptr == 10'(H_ACTIVE - 1));
  // A last pixel landing in the swap cycle still completes the outgoing line.
  assign line_done = (state == FULL) || last_xfer;
  assign v_next    = I_v_cnt + 12'd1;
  assign swap      = (I_h_cnt == 12'(H_TOTAL - 1)) &&
                     (v_next >= 12'(V_START)) && (v_next <= 12'(V_START + V_ACTIVE - 1));
  assign h_act     = (I_h_cnt >= 12'(H_START)) && (I_h_cnt < 12'(H_START + H_ACTIVE));
  assign v_act     = (I_v_cnt >= 12'(V_START)) && (I_v_cnt < 12'(V_START + V_ACTIVE));
  assign rd_addr   = 10'(I_h_cnt - 12'(H_START));

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= FILL;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      rd_valid    <= 1'b0;
      started     <= 1'b0;
      O_pix_ready <= 1'b0;
      O_line_req  <= 1'b0;
      O_line_num  <= '0;
      O_underrun  <= 1'b0;
    end else begin
      started    <= 1'b1;
      O_line_req <= swap || !started;
      if (swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        wr_ptr      <= '0;
        state       <= FILL;
        O_pix_ready <= 1'b1;
        rd_valid    <= line_done;
        if (!line_done)
          O_underrun <= 1'b1;
        O_line_num  <= (O_line_num == 10'(V_ACTIVE - 1)) ? 10'd0 : O_line_num + 10'd1;
      end else if (xfer) begin
        wr_ptr <= wr_ptr + 10'd1;
        if (last_xfer) begin
          state       <= FULL;
          O_pix_ready <= 1'b0;
        end
      end else begin
        O_pix_ready <= (state == FILL);
      end
    end
  end

  // Write port: the fill bank, always the one not being displayed.
  always_ff @(posedge I_clk) begin
    if (xfer && !wr_bank)
      bank0[wr_ptr] <= I_pix_data;
    if (xfer && wr_bank)
      bank1[wr_ptr] <= I_pix_data;
  end

  // Stage p1: synchronous read straight into the colour register, sync delayed to match.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rgb_p1 <= '0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      hs_p1 <= I_hs;
      vs_p1 <= I_vs;
      if (h_act && v_act && pat_on)
        rgb_p1 <= pat_pix;
      else if (h_act && v_act && rd_valid)
        rgb_p1 <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
      else
        rgb_p1 <= '0;
    end
  end

  assign O_red   = rgb_p1[11:8];
  assign O_green = rgb_p1[7:4];
  assign O_blue  = rgb_p1[3:0];
  assign O_hs    = hs_p1;
  assign O_vs    = vs_p1;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Randomized bench for vga_line_buffer against a queue/array model of the line hand-off.
module tb_vga_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        tg_hs;
  logic        tg_vs;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pat_en;
  logic        pix_ready;
  logic        line_req;
  logic [9:0]  line_num;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hs;
  logic        vs;
  logic        underrun;

  always #20 clk = ~clk;

  vga_line_buffer dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_h_cnt     (h_cnt),
    .I_v_cnt     (v_cnt),
    .I_hs        (tg_hs),
    .I_vs        (tg_vs),
    .I_pix_data  (pix_data),
    .I_pix_valid (pix_valid),
`ifdef VGA_LB_TESTPAT_EN
    .I_pat_en    (pat_en),
`endif
    .O_pix_ready (pix_ready),
    .O_line_req  (line_req),
    .O_line_num  (line_num),
    .O_red       (red),
    .O_green     (green),
    .O_blue      (blue),
    .O_hs        (hs),
    .O_vs        (vs),
    .O_underrun  (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: the line being collected, the line on screen, and counters.
  logic [11:0] m_fill [$];
  logic [11:0] m_disp [640];
  bit          m_disp_ok;
  int          m_lnum;
  bit          m_unr;
  bit          m_alive;
  bit          m_req;
  logic [11:0] e_rgb;
  logic        e_hs;
  logic        e_vs;
  logic [11:0] bar_tab [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF,
                               12'h000, 12'hFF0, 12'hF0F, 12'h0FF};

  // Upstream source: pixel k of the current line is k*src_mul+src_add.
  int src_mul   = 1;
  int src_add   = 0;
  int src_limit = 640;
  int src_pct   = 100;

  function automatic void model_edge();
    int  h;
    int  v;
    bit  rdy;
    bit  swp;
    h = int'(h_cnt);
    v = int'(v_cnt);
    if (rst) begin
      m_fill.delete();
      m_disp_ok = 0;
      m_lnum    = 0;
      m_unr     = 0;
      m_alive   = 0;
      m_req     = 0;
      e_rgb     = '0;
      e_hs      = 1'b1;
      e_vs      = 1'b1;
      return;
    end
    rdy  = m_alive && (m_fill.size() < 640);
    e_hs = tg_hs;
    e_vs = tg_vs;
    if (h >= 144 && h < 784 && v >= 35 && v < 515) begin
      if (pat_en)         e_rgb = bar_tab[(h - 144) / 80];
      else if (m_disp_ok) e_rgb = m_disp[h - 144];
      else                e_rgb = '0;
    end else begin
      e_rgb = '0;
    end
    if (pix_valid && rdy)
      m_fill.push_back(pix_data);
    swp     = (h == 799) && (v + 1 >= 35) && (v + 1 <= 514);
    m_req   = !m_alive || swp;
    m_alive = 1;
    if (swp) begin
      if (m_fill.size() == 640) begin
        foreach (m_disp[i]) m_disp[i] = m_fill[i];
        m_disp_ok = 1;
      end else begin
        m_disp_ok = 0;
        m_unr     = 1;
      end
      m_fill.delete();
      m_lnum = (m_lnum + 1) % 480;
    end
  endfunction

  task automatic cyc(input int h, input int v, input bit r);
    int idx;
    idx       = m_fill.size();
    rst       = r;
    h_cnt     = 12'(h);
    v_cnt     = 12'(v);
    tg_hs     = (h >= 96);
    tg_vs     = (v >= 2);
    pix_valid = !r && (idx < src_limit) && ($urandom_range(99) < src_pct);
    pix_data  = 12'(idx * src_mul + src_add);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_eq("rgb",      {red, green, blue}, e_rgb);
    chk_eq("hs",       hs, e_hs);
    chk_eq("vs",       vs, e_vs);
    chk_eq("ready",    pix_ready, m_alive && (m_fill.size() < 640));
    chk_eq("line_req", line_req, m_req);
    chk_eq("line_num", line_num, 10'(m_lnum));
    chk_eq("underrun", underrun, m_unr);
  endtask

  task automatic run_line(input int v, input int h0, input int rst_h);
    for (int h = h0; h < 800; h++)
      cyc(h, v, h == rst_h);
  endtask

  task automatic rand_src();
    int p;
    src_mul   = int'($urandom_range(1, 4095));
    src_add   = int'($urandom_range(0, 4095));
    src_limit = 640;
    p         = int'($urandom_range(0, 3));
    src_pct   = (p == 0) ? 70 : (p == 1) ? 100 : 92;
  endtask

  initial begin
    rst       = 1'b1;
    h_cnt     = '0;
    v_cnt     = '0;
    tg_hs     = 1'b1;
    tg_vs     = 1'b1;
    pix_data  = '0;
    pix_valid = 1'b0;
    pat_en    = 1'b0;
    @(negedge clk);

    // Reset, then the initial request for line 0.
    repeat (3) cyc(0, 0, 1'b1);
    chk_eq("t1_rgb", {red, green, blue}, 12'h000);
    chk_eq("t1_hs",  hs, 1'b1);
    cyc(0, 33, 1'b0);
    chk_eq("t1_req",   line_req, 1'b1);
    chk_eq("t1_lnum",  line_num, 10'd0);
    chk_eq("t1_ready", pix_ready, 1'b1);
    cyc(1, 33, 1'b0);
    chk_eq("t1_req_once", line_req, 1'b0);

    // Ramp line i -> displayed on v=35; then a 300-pixel line.
    run_line(33, 2, -1);
    run_line(34, 0, -1);
    chk_eq("t2_lnum", line_num, 10'd1);
    src_limit = 300;
    for (int h = 0; h < 800; h++) begin
      cyc(h, 35, 1'b0);
      if (h == 144 + 517) chk_eq("t2_pix517", {red, green, blue}, 12'd517);
    end
    chk_eq("t3_unr",   underrun, 1'b1);
    chk_eq("t3_ready", pix_ready, 1'b1);

    // Random data and valid gaps across many lines.
    for (int v = 36; v < 46; v++) begin
      rand_src();
      run_line(v, 0, -1);
    end

    // Fast-forward: one swap-position cycle per line to the frame wrap.
    for (int v = 46; v < 525; v++) begin
      cyc(799, v, 1'b0);
      if (v == 512) chk_eq("t4_lnum479", line_num, 10'd479);
      if (v == 513) chk_eq("t4_wrap",    line_num, 10'd0);
    end
    for (int v = 0; v < 33; v++)
      cyc(799, v, 1'b0);
    for (int v = 33; v < 37; v++) begin
      rand_src();
      run_line(v, 0, -1);
    end

    // Reset mid-line at h=400.
    rand_src();
    run_line(37, 0, 400);
    chk_eq("t5_unr_after_swap", underrun, 1'b1);
    for (int v = 38; v < 41; v++) begin
      rand_src();
      run_line(v, 0, -1);
    end

`ifdef VGA_LB_TESTPAT_EN
    pat_en = 1'b1;
    for (int h = 0; h < 800; h++) begin
      cyc(h, 41, 1'b0);
      if (h == 144) chk_eq("t6_h144", {red, green, blue}, 12'hF00);
      if (h == 704) chk_eq("t6_h704", {red, green, blue}, 12'h0FF);
      if (h == 784) chk_eq("t6_h784", {red, green, blue}, 12'h000);
    end
    pat_en = 1'b0;
    run_line(42, 0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
